// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and kernel tap indices for the 3x3 window MAC.
//   PIX_W/WGT_W   unsigned pixel and signed weight widths
//   PROD_W        signed pixel x weight product width (9b x 8b)
//   CSUM_W        width of one column sum of three products
//   TAP_*         base tap index of each kernel row (k = 3*row + col)
package conv_pkg;
    localparam int PIX_W       = 8;
    localparam int WGT_W       = 8;
    localparam int PROD_W      = 17;
    localparam int KERNEL_TAPS = 9;
    localparam int COL_W       = 3 * PIX_W;
    localparam int CSUM_W      = PROD_W + 2;
    localparam int TAP_TOP     = 0;
    localparam int TAP_MID     = 3;
    localparam int TAP_BOT     = 6;
endpackage

// File: rtl/conv_col_mac.sv
// conv_col_mac: one window column x three kernel weights -> registered products -> registered sum.
//   clk, rst   clock, asynchronous active-low reset
//   col_i      column word, [23:16] top .. [7:0] bottom, unsigned pixels
//   w_i        signed weights packed top row in the low byte
//   sum_o      signed sum of the three products, two cycles after col_i
module conv_col_mac
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COL_W-1:0]         col_i,
    input  logic [3*WGT_W-1:0]       w_i,
    output logic signed [CSUM_W-1:0] sum_o
);
    logic signed [PROD_W-1:0] prod_q [3];
    logic signed [CSUM_W-1:0] sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= '{default: '0};
            sum_q  <= '0;
        end else begin
            // pixel is zero-extended so it stays non-negative in the signed product
            for (int r = 0; r < 3; r++)
                prod_q[r] <= PROD_W'($signed({1'b0, col_i[COL_W-1-r*PIX_W -: PIX_W]}))
                           * PROD_W'($signed(w_i[r*WGT_W +: WGT_W]));
            sum_q <= CSUM_W'(prod_q[0]) + CSUM_W'(prod_q[1]) + CSUM_W'(prod_q[2]);
        end
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: shifts 3-pixel columns into a 3x3 window and computes a signed MAC per window.
//   clk, rst              clock, asynchronous active-low reset
//   p, col_valid          column word ([23:16] top) and its strobe
//   row_start             with col_valid: first column of a new row
//   w_we, w_addr, w_data  kernel write, k = 3*row + col, col 0 = oldest column
//   acc_out, pix_out      signed sum and saturated 8-bit pixel, held between results
//   out_valid             one-cycle pulse per window, four cycles after its last column
module conv3x3_window_mac
    import conv_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      p,
    input  logic             col_valid,
    input  logic             row_start,
    input  logic             w_we,
    input  logic [3:0]       w_addr,
    input  logic [7:0]       w_data,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       pix_out,
    output logic             out_valid
);
    logic [COL_W-1:0]         col_q [3];
    logic [WGT_W-1:0]         w_q [KERNEL_TAPS];
    logic [1:0]               fill_q, fill_d;
    logic [2:0]               v_q;
    logic signed [CSUM_W-1:0] csum [3];
    logic signed [ACC_W-1:0]  acc_sum, acc_sh;
    logic [ACC_W-1:0]         acc_d;
    logic [7:0]               pix_d;

    for (genvar c = 0; c < 3; c++) begin : g_col
        conv_col_mac u_col (
            .clk  (clk),
            .rst  (rst),
            .col_i(col_q[c]),
            .w_i  ({w_q[TAP_BOT+c], w_q[TAP_MID+c], w_q[TAP_TOP+c]}),
            .sum_o(csum[c])
        );
    end

    always_comb begin
        // a row start restarts filling so columns of the previous row never join the window
        fill_d  = row_start ? 2'd1 : (fill_q == 2'd3 ? 2'd3 : fill_q + 2'd1);
        acc_sum = ACC_W'(csum[0]) + ACC_W'(csum[1]) + ACC_W'(csum[2]);
        acc_sh  = acc_sum >>> SHIFT;
        acc_d   = (RELU != 0 && acc_sum[ACC_W-1]) ? '0 : acc_sum;
        pix_d   = (acc_sum[ACC_W-1] || acc_sum == '0) ? 8'd0 :
                  (acc_sh > ACC_W'(255) ? 8'hFF : acc_sh[7:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '{default: '0};
            w_q       <= '{default: '0};
            fill_q    <= '0;
            v_q       <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            pix_out   <= '0;
        end else begin
            if (w_we && w_addr <= 4'd8)
                w_q[w_addr] <= w_data;
            if (col_valid) begin
                col_q[0] <= col_q[1];
                col_q[1] <= col_q[2];
                col_q[2] <= p;
                fill_q   <= fill_d;
            end
            v_q       <= {v_q[1:0], col_valid && fill_d == 2'd3};
            out_valid <= v_q[2];
            if (v_q[2]) begin
                acc_out <= acc_d;
                pix_out <= pix_d;
            end
        end
    end
endmodule
